// File: rtl/multi_chan_accum_pkg.sv
// Shared types and helpers for the multi-channel accumulator.
package multi_chan_accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2
  } accum_state_t;

  // Select width for n channels; a single channel still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accum_channel.sv
// One accumulator channel: IDLE->WAIT->ACC handshake, settle delay,
// wrap or saturating add with sticky overflow, one-cycle completion pulse.
module accum_channel
  import multi_chan_accum_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DELAY    = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int            CW        = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(DELAY - 1);

  accum_state_t     state_reg;
  logic [CW-1:0]    wait_cnt_reg;
  logic [WIDTH-1:0] opnd_reg;
  logic [WIDTH-1:0] count_reg;
  logic             ovf_reg;
  logic             done_reg;
  logic             busy_reg;

  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] add_next;

  // Carry-out of the extended add is the overflow flag.
  always_comb begin
    add_full = {1'b0, count_reg} + {1'b0, opnd_reg};
    add_next = add_full[WIDTH-1:0];
    if (SATURATE && add_full[WIDTH]) begin
      add_next = '1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      opnd_reg     <= '0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else if (clear) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      opnd_reg     <= '0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg    <= WAIT;
            opnd_reg     <= value;
            wait_cnt_reg <= WAIT_LOAD;
            busy_reg     <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt_reg == '0) begin
            state_reg <= ACC;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - CW'(1);
          end
        end
        ACC: begin
          count_reg <= add_next;
          ovf_reg   <= ovf_reg | add_full[WIDTH];
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/multi_chan_accum.sv
// NCH independent enable-triggered accumulators with a selectable
// readback channel driving the sum port and the LED bank.
module multi_chan_accum
  import multi_chan_accum_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NCH      = 4,
  parameter int DELAY    = 1,
  parameter bit SATURATE = 1'b0,
  parameter int LED_LSB  = 16,
  parameter int LED_W    = 8,
  localparam int SW      = sel_width(NCH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clear,
  input  logic [NCH-1:0]       enable,
  input  logic [NCH*WIDTH-1:0] value,
  input  logic [SW-1:0]        sel,
  output logic [LED_W-1:0]     led,
  output logic [WIDTH-1:0]     sum,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       done,
  output logic [NCH-1:0]       ovf
);

  logic [WIDTH-1:0] count_arr [NCH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      accum_channel #(
        .WIDTH    (WIDTH),
        .DELAY    (DELAY),
        .SATURATE (SATURATE)
      ) u_chan (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (clear),
        .enable (enable[gi]),
        .value  (value[gi*WIDTH +: WIDTH]),
        .count  (count_arr[gi]),
        .busy   (busy[gi]),
        .done   (done[gi]),
        .ovf    (ovf[gi])
      );
    end
  endgenerate

  // Unmatched select codes (NCH not a power of two) fall through to zero.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SW'(i)) begin
        sum = count_arr[i];
      end
    end
  end

  assign led = sum[LED_LSB +: LED_W];

endmodule

// File: tb/tb_multi_chan_accum.sv
// Scoreboard bench: stimulus pushes expected completions, a negedge monitor
// pops and compares them whenever a done pulse appears.
module tb_multi_chan_accum;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // DUT A: 32-bit, 4 channels, DELAY=1, wrap
  logic         a_clear;
  logic [3:0]   a_en;
  logic [127:0] a_val;
  logic [1:0]   a_sel;
  logic [7:0]   a_led;
  logic [31:0]  a_sum;
  logic [3:0]   a_busy, a_done, a_ovf;

  // DUT B (saturate) and DUT C (wrap): 8-bit, 3 channels, DELAY=4, shared inputs
  logic        b_clear;
  logic [2:0]  b_en;
  logic [23:0] b_val;
  logic [1:0]  b_sel;
  logic [3:0]  b_led, c_led;
  logic [7:0]  b_sum, c_sum;
  logic [2:0]  b_busy, b_done, b_ovf, c_busy, c_done, c_ovf;

  multi_chan_accum #(.WIDTH(32), .NCH(4), .DELAY(1), .SATURATE(1'b0), .LED_LSB(16), .LED_W(8)) dut_a (
    .CLK(CLK), .RST(RST), .clear(a_clear), .enable(a_en), .value(a_val), .sel(a_sel),
    .led(a_led), .sum(a_sum), .busy(a_busy), .done(a_done), .ovf(a_ovf));

  multi_chan_accum #(.WIDTH(8), .NCH(3), .DELAY(4), .SATURATE(1'b1), .LED_LSB(4), .LED_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .clear(b_clear), .enable(b_en), .value(b_val), .sel(b_sel),
    .led(b_led), .sum(b_sum), .busy(b_busy), .done(b_done), .ovf(b_ovf));

  multi_chan_accum #(.WIDTH(8), .NCH(3), .DELAY(4), .SATURATE(1'b0), .LED_LSB(4), .LED_W(4)) dut_c (
    .CLK(CLK), .RST(RST), .clear(b_clear), .enable(b_en), .value(b_val), .sel(b_sel),
    .led(c_led), .sum(c_sum), .busy(c_busy), .done(c_done), .ovf(c_ovf));

  typedef struct {
    int          dut;
    int          ch;
    logic [31:0] sum;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // lat = edges from acceptance to the done-visible edge
  task automatic push(input int d, input int ch, input logic [31:0] s, input logic o, input int lat);
    exp_t e;
    e.dut = d;
    e.ch  = ch;
    e.sum = s;
    e.ovf = o;
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic mon(input int d, input logic [3:0] dn, input logic [3:0] ov,
                     input logic [31:0] s, input int sl);
    int idx;
    for (int c = 0; c < 4; c++) begin
      if (dn[c]) begin
        idx = -1;
        for (int k = 0; k < sb.size(); k++)
          if (idx < 0 && sb[k].dut == d && sb[k].ch == c) idx = k;
        if (idx < 0) begin
          checks++;
          $display("FAIL unexpected_done dut%0d ch%0d: got done at cycle %0d, want no done", d, c, cyc);
        end else begin
          chk($sformatf("done_cycle dut%0d ch%0d", d, c), cyc, sb[idx].cyc);
          chk($sformatf("done_ovf dut%0d ch%0d", d, c), {31'b0, ov[c]}, {31'b0, sb[idx].ovf});
          if (sl == c) chk($sformatf("done_sum dut%0d ch%0d", d, c), s, sb[idx].sum);
          sb.delete(idx);
        end
      end
    end
  endtask

  always @(negedge CLK) begin
    mon(0, a_done, a_ovf, a_sum, int'(a_sel));
    mon(1, {1'b0, b_done}, {1'b0, b_ovf}, {24'b0, b_sum}, int'(b_sel));
    mon(2, {1'b0, c_done}, {1'b0, c_ovf}, {24'b0, c_sum}, int'(b_sel));
  end

  initial begin
    int lows, dcount, bad, offs;
    a_clear = 0; a_en = '0; a_val = '0; a_sel = '0;
    b_clear = 0; b_en = '0; b_val = '0; b_sel = '0;

    // Reset state
    tick(3);
    chk("rst_a_sum", a_sum, 0);
    chk("rst_a_led", a_led, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_b_sum", b_sum, 0);
    chk("rst_c_busy", c_busy, 0);
    RST = 0;
    tick(1);

    // Basic add on ch0, legacy 3-cycle path
    a_val[0 +: 32] = 32'h0001_0000; a_en[0] = 1'b1;
    push(0, 0, 32'h0001_0000, 1'b0, 2);
    tick(1); a_en = '0;
    chk("busy_after_accept", a_busy, 4'b0001);
    tick(1);
    chk("busy_in_acc", a_busy, 4'b0001);
    tick(1);
    chk("done_pulse", a_done, 4'b0001);
    chk("busy_falls_with_done", a_busy, 4'b0000);
    chk("sum_ch0", a_sum, 32'h0001_0000);
    chk("led_ch0", a_led, 8'h01);
    tick(1);
    chk("done_one_cycle", a_done, 4'b0000);

    // Operand latched at acceptance
    a_sel = 2'd2; a_val[64 +: 32] = 32'd5; a_en[2] = 1'b1;
    push(0, 2, 32'd5, 1'b0, 2);
    tick(1); a_en = '0; a_val[64 +: 32] = 32'hFFFF_FFFF;
    tick(3);
    chk("latch_sum", a_sum, 32'd5);
    chk("latch_ovf", a_ovf, 4'b0000);

    // Simultaneous enables after a clear
    a_clear = 1'b1; tick(1); a_clear = 1'b0;
    chk("clear_sum", a_sum, 0);
    for (int i = 0; i < 4; i++) begin
      a_val[i*32 +: 32] = 32'(i + 1);
      push(0, i, 32'(i + 1), 1'b0, 2);
    end
    a_en = 4'hF;
    tick(1); a_en = '0;
    chk("simul_busy", a_busy, 4'hF);
    tick(2);
    chk("simul_done", a_done, 4'hF);
    tick(1);
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s); #1;
      chk($sformatf("sel_sweep_%0d", s), a_sum, 32'(s + 1));
    end

    // Wrap overflow on ch1 (2 + 0xFFFFFFFF), then sticky on the next add
    a_sel = 2'd1; a_val[32 +: 32] = 32'hFFFF_FFFF; a_en[1] = 1'b1;
    push(0, 1, 32'd1, 1'b1, 2);
    tick(1); a_en = '0; tick(3);
    chk("wrap_sum", a_sum, 32'd1);
    chk("wrap_ovf", a_ovf, 4'b0010);
    a_val[32 +: 32] = 32'd3; a_en[1] = 1'b1;
    push(0, 1, 32'd4, 1'b1, 2);
    tick(1); a_en = '0; tick(3);
    chk("sticky_sum", a_sum, 32'd4);
    chk("sticky_ovf", a_ovf, 4'b0010);

    // Clear during WAIT aborts with no done
    a_sel = 2'd3; a_val[96 +: 32] = 32'd7; a_en[3] = 1'b1;
    tick(1); a_en = '0;
    chk("abort_busy_wait", a_busy, 4'b1000);
    a_clear = 1'b1; tick(1); a_clear = 1'b0;
    chk("abort_busy", a_busy, 0);
    chk("abort_ovf", a_ovf, 0);
    tick(3);
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s); #1;
      chk($sformatf("abort_sum_%0d", s), a_sum, 0);
    end
    tick(1);

    // Enable in the same cycle as clear is dropped
    a_clear = 1'b1; a_en = 4'hF; a_val = {4{32'd1}};
    tick(1); a_clear = 1'b0; a_en = '0;
    chk("clear_drops_enable", a_busy, 0);
    tick(3);

    // 8-bit overflow: saturate (B) vs wrap (C)
    b_sel = 2'd0; b_val[0 +: 8] = 8'hF0; b_en[0] = 1'b1;
    push(1, 0, 32'hF0, 1'b0, 5); push(2, 0, 32'hF0, 1'b0, 5);
    tick(1); b_en = '0; tick(6);
    b_val[0 +: 8] = 8'h20; b_en[0] = 1'b1;
    push(1, 0, 32'hFF, 1'b1, 5); push(2, 0, 32'h10, 1'b1, 5);
    tick(1); b_en = '0; tick(6);
    chk("sat_sum", {24'b0, b_sum}, 32'hFF);
    chk("wrap8_sum", {24'b0, c_sum}, 32'h10);
    chk("sat_ovf", b_ovf, 3'b001);
    chk("wrap8_ovf", c_ovf, 3'b001);
    chk("sat_led", b_led, 4'hF);
    chk("wrap8_led", c_led, 4'h1);
    b_val[0 +: 8] = 8'h01; b_en[0] = 1'b1;
    push(1, 0, 32'hFF, 1'b1, 5); push(2, 0, 32'h11, 1'b1, 5);
    tick(1); b_en = '0; tick(6);
    chk("wrap8_sum2", {24'b0, c_sum}, 32'h11);
    chk("wrap8_ovf_sticky", c_ovf, 3'b001);
    chk("sat_ovf_sticky", b_ovf, 3'b001);

    // Out-of-range select reads zero
    b_sel = 2'd3; #1;
    chk("oob_sel_sum_b", {24'b0, b_sum}, 0);
    chk("oob_sel_led_b", b_led, 0);
    chk("oob_sel_sum_c", {24'b0, c_sum}, 0);
    tick(1);

    // Enable held 20 cycles with DELAY=4: re-accepted every 6 cycles
    b_sel = 2'd1; b_val[8 +: 8] = 8'd3; b_en[1] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      push(1, 1, 32'(3 * (j + 1)), 1'b0, 5 + 6 * j);
      push(2, 1, 32'(3 * (j + 1)), 1'b0, 5 + 6 * j);
    end
    lows = 0; dcount = 0; bad = 0; offs = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!b_busy[1]) begin
        lows++;
        if (!b_done[1]) bad++;
      end
      if (b_done[1]) begin
        dcount++;
        if (i != 5 && i != 11 && i != 17) offs++;
      end
    end
    b_en = '0;
    chk("held_done_pulses", dcount, 3);
    chk("held_busy_low_cycles", lows, 3);
    chk("held_busy_low_only_on_accept", bad, 0);
    chk("held_done_spacing", offs, 0);
    tick(6);
    chk("held_sum_b", {24'b0, b_sum}, 32'd12);
    chk("held_sum_c", {24'b0, c_sum}, 32'd12);

    // Asynchronous reset mid-ACC
    a_sel = 2'd1; a_val[32 +: 32] = 32'd6; a_en[1] = 1'b1;
    push(0, 1, 32'd6, 1'b0, 2);
    tick(1); a_en = '0; tick(3);
    chk("pre_rst_sum", a_sum, 32'd6);
    a_val[0 +: 32] = 32'd9; a_en[0] = 1'b1;
    tick(1); a_en = '0; tick(1);
    chk("pre_rst_busy_acc", a_busy, 4'b0001);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_sum", a_sum, 0);
    chk("async_rst_led", a_led, 0);
    chk("async_rst_busy", a_busy, 0);
    chk("async_rst_done", a_done, 0);
    chk("async_rst_ovf", a_ovf, 0);
    chk("async_rst_sum_b", {24'b0, b_sum}, 0);
    chk("async_rst_ovf_b", b_ovf, 0);
    chk("async_rst_sum_c", {24'b0, c_sum}, 0);
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    tick(2);
    chk("post_rst_no_done", a_done, 0);
    a_sel = 2'd0; a_val[0 +: 32] = 32'd9; a_en[0] = 1'b1;
    push(0, 0, 32'd9, 1'b0, 2);
    tick(1); a_en = '0; tick(3);
    chk("resume_sum", a_sum, 32'd9);

    tick(5);
    foreach (sb[k]) begin
      checks++;
      $display("FAIL missing_done dut%0d ch%0d: got no done, want done at cycle %0d", sb[k].dut, sb[k].ch, sb[k].cyc);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
